// File: rtl/bp_pkg.sv
// Shared types and helpers for the history-based branch predictor.
package bp_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  localparam int MODE_LOCAL  = 0;
  localparam int MODE_GSHARE = 1;

  // Saturating up/down step for counters up to 4 bits wide.
  function automatic logic [3:0] ctr_sat(input logic [3:0] ctr,
                                         input logic       up,
                                         input int         width);
    logic [3:0] max_v;
    max_v = 4'((5'd1 << width) - 5'd1);
    if (up) begin
      return (ctr >= max_v) ? ctr : ctr + 4'd1;
    end
    return (ctr == 4'd0) ? ctr : ctr - 4'd1;
  endfunction

endpackage

// File: rtl/pht_ctr_array.sv
// Pattern history table: saturating counters with registered MSB read,
// read-modify-write update port and an initialisation sweep write port.
module pht_ctr_array
  import bp_pkg::*;
#(
  parameter int IDX_W     = 6,
  parameter int CTR_WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sweep_we_i,
  input  logic [IDX_W-1:0] sweep_idx_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  output logic             rd_msb_o
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

  logic [CTR_WIDTH-1:0] ctr_q [DEPTH];
  logic                 rd_msb_q;

  // Counter storage: no reset, contents come only from the sweep.
  // Sweep and update never coincide because updates need ready.
  always_ff @(posedge clk) begin
    if (sweep_we_i) begin
      ctr_q[sweep_idx_i] <= CTR_INIT;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= CTR_WIDTH'(ctr_sat(4'(ctr_q[upd_idx_i]), upd_taken_i, CTR_WIDTH));
    end
  end

  // Registered lookup; reads the pre-update value, forced low without a request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_msb_q <= 1'b0;
    end else begin
      rd_msb_q <= rd_en_i & ctr_q[rd_idx_i][CTR_WIDTH-1];
    end
  end

  assign rd_msb_o = rd_msb_q;

endmodule

// File: rtl/hist_predictor.sv
// Two-level branch direction predictor: local history (BHT) or gshare,
// indexing a table of saturating counters that is swept to weakly
// not-taken after every reset.
module hist_predictor
  import bp_pkg::*;
#(
  parameter int BHR_WIDTH  = 4,
  parameter int BHT_BIT    = 5,
  parameter int PHT_PC_BIT = 2,
  parameter int CTR_WIDTH  = 2,
  parameter int MODE       = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if1_valid,
  input  logic [31:0] if1_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic        ready,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken
);

  localparam int I         = BHR_WIDTH + PHT_PC_BIT;
  localparam int BHT_DEPTH = 1 << BHT_BIT;

  bp_state_e            state_q;
  logic [I-1:0]         sweep_q;
  logic                 ready_q;
  logic                 pred_valid_q;
  logic [BHR_WIDTH-1:0] bht_q [BHT_DEPTH];
  logic [BHR_WIDTH-1:0] ghr_q;

  logic                 sweep_we;
  logic                 rd_en;
  logic                 upd_en;
  logic [BHR_WIDTH-1:0] rd_hist;
  logic [BHR_WIDTH-1:0] upd_hist;
  logic [BHR_WIDTH-1:0] upd_bhr;
  logic [I-1:0]         rd_idx;
  logic [I-1:0]         upd_idx;
  logic                 unused_pc;

  assign sweep_we = (state_q == ST_INIT) && rst_n;
  assign rd_en    = if1_valid & ready_q;
  assign upd_en   = upd_valid & ready_q;
  assign upd_bhr  = bht_q[upd_pc[BHT_BIT+1:2]];

  // Only the low PC bits index anything; higher bits alias freely.
  assign unused_pc = ^{if1_pc, upd_pc};

  // History selection and table index for lookup and update, both from
  // the history as it stands before this cycle's update.
  always_comb begin
    rd_hist  = bht_q[if1_pc[BHT_BIT+1:2]];
    upd_hist = upd_bhr;
    if (MODE == MODE_GSHARE) begin
      rd_hist  = ghr_q ^ if1_pc[I+1:PHT_PC_BIT+2];
      upd_hist = ghr_q ^ upd_pc[I+1:PHT_PC_BIT+2];
    end
    rd_idx  = {rd_hist, if1_pc[PHT_PC_BIT+1:2]};
    upd_idx = {upd_hist, upd_pc[PHT_PC_BIT+1:2]};
  end

  // Control FSM: INIT sweeps the table, RUN serves lookups and updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      ready_q      <= 1'b0;
      pred_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ready_q      <= 1'b0;
          pred_valid_q <= 1'b0;
          sweep_q      <= sweep_q + 1'b1;
          if (sweep_q == '1) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          ready_q      <= 1'b1;
          pred_valid_q <= rd_en;
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  // History registers: cleared in one cycle on reset, shifted on update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= '0;
      end
      ghr_q <= '0;
    end else if (upd_en) begin
      if (MODE == MODE_GSHARE) begin
        ghr_q <= BHR_WIDTH'({ghr_q, upd_taken});
      end else begin
        bht_q[upd_pc[BHT_BIT+1:2]] <= BHR_WIDTH'({upd_bhr, upd_taken});
      end
    end
  end

  pht_ctr_array #(
    .IDX_W     (I),
    .CTR_WIDTH (CTR_WIDTH)
  ) u_pht (
    .clk         (clk),
    .rst_n       (rst_n),
    .sweep_we_i  (sweep_we),
    .sweep_idx_i (sweep_q),
    .rd_en_i     (rd_en),
    .rd_idx_i    (rd_idx),
    .upd_en_i    (upd_en),
    .upd_idx_i   (upd_idx),
    .upd_taken_i (upd_taken),
    .rd_msb_o    (pred_taken)
  );

  assign pred_valid = pred_valid_q;
  assign ready      = ready_q;

endmodule
